// File: rtl/axi_wburst_buffer.sv
// Store-and-forward AXI write buffer: holds each AW until its full W burst
// is buffered, then issues AW and W back-to-back. AR/R/B pass straight through.
package axi_wburst_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;
  typedef aw_chan_t ar_chan_t;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_wburst_buffer
  import axi_wburst_pkg::*;
#(
  parameter int unsigned NumAw  = 4,
  parameter int unsigned WDepth = 8,
  parameter type axi_aw_chan_t = aw_chan_t,
  parameter type axi_w_chan_t  = w_chan_t,
  parameter type axi_req_t     = req_t,
  parameter type axi_rsp_t     = resp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t slv_req_i,
  output axi_rsp_t slv_resp_o,
  output axi_req_t mst_req_o,
  input  axi_rsp_t mst_resp_i,
  output logic     busy_o
);

  localparam int unsigned AwIdxW = (NumAw > 1) ? $clog2(NumAw) : 1;
  localparam int unsigned WIdxW  = (WDepth > 1) ? $clog2(WDepth) : 1;
  localparam int unsigned AwCntW = $clog2(NumAw + 1);
  localparam int unsigned WCntW  = $clog2(WDepth + 1);

  axi_aw_chan_t      aw_mem_q [NumAw];
  logic [AwIdxW-1:0] aw_wr_q, aw_wr_d, aw_rd_q, aw_rd_d;
  logic [AwCntW-1:0] aw_cnt_q, aw_cnt_d;
  axi_w_chan_t       w_mem_q [WDepth];
  logic [WIdxW-1:0]  w_wr_q, w_wr_d, w_rd_q, w_rd_d;
  logic [WCntW-1:0]  w_cnt_q, w_cnt_d;
  logic [WCntW-1:0]  cmpl_q, cmpl_d;
  logic [AwCntW-1:0] iss_q, iss_d;

  logic aw_full, aw_empty, w_full, w_empty;
  logic aw_push, aw_pop, aw_out_v;
  logic w_push, w_pop, w_out_v;
  logic w_push_last, w_pop_last;

  assign aw_full  = aw_cnt_q == AwCntW'(NumAw);
  assign aw_empty = aw_cnt_q == '0;
  assign w_full   = w_cnt_q == WCntW'(WDepth);
  assign w_empty  = w_cnt_q == '0;

  assign aw_push  = slv_req_i.aw_valid & ~aw_full;
  assign aw_out_v = ~aw_empty & (cmpl_q != '0);
  assign aw_pop   = aw_out_v & mst_resp_i.aw_ready;

  assign w_push      = slv_req_i.w_valid & ~w_full;
  assign w_push_last = w_push & slv_req_i.w.last;
  assign w_out_v     = ~w_empty & (iss_q != '0);
  assign w_pop       = w_out_v & mst_resp_i.w_ready;
  assign w_pop_last  = w_pop & w_mem_q[w_rd_q].last;

  always_comb begin
    aw_wr_d = aw_wr_q;
    aw_rd_d = aw_rd_q;
    w_wr_d  = w_wr_q;
    w_rd_d  = w_rd_q;
    if (aw_push)
      aw_wr_d = (aw_wr_q == AwIdxW'(NumAw - 1)) ? '0 : aw_wr_q + AwIdxW'(1);
    if (aw_pop)
      aw_rd_d = (aw_rd_q == AwIdxW'(NumAw - 1)) ? '0 : aw_rd_q + AwIdxW'(1);
    if (w_push)
      w_wr_d = (w_wr_q == WIdxW'(WDepth - 1)) ? '0 : w_wr_q + WIdxW'(1);
    if (w_pop)
      w_rd_d = (w_rd_q == WIdxW'(WDepth - 1)) ? '0 : w_rd_q + WIdxW'(1);
    aw_cnt_d = aw_cnt_q + AwCntW'(aw_push) - AwCntW'(aw_pop);
    w_cnt_d  = w_cnt_q + WCntW'(w_push) - WCntW'(w_pop);
    // A burst leaves "complete" when its AW issues, and "issued" on its last beat
    cmpl_d   = cmpl_q + WCntW'(w_push_last) - WCntW'(aw_pop);
    iss_d    = iss_q + AwCntW'(aw_pop) - AwCntW'(w_pop_last);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_wr_q  <= '0;
      aw_rd_q  <= '0;
      aw_cnt_q <= '0;
      w_wr_q   <= '0;
      w_rd_q   <= '0;
      w_cnt_q  <= '0;
      cmpl_q   <= '0;
      iss_q    <= '0;
    end else begin
      aw_wr_q  <= aw_wr_d;
      aw_rd_q  <= aw_rd_d;
      aw_cnt_q <= aw_cnt_d;
      w_wr_q   <= w_wr_d;
      w_rd_q   <= w_rd_d;
      w_cnt_q  <= w_cnt_d;
      cmpl_q   <= cmpl_d;
      iss_q    <= iss_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_push) aw_mem_q[aw_wr_q] <= slv_req_i.aw;
    if (w_push) w_mem_q[w_wr_q] <= slv_req_i.w;
  end

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw       = aw_mem_q[aw_rd_q];
    mst_req_o.aw_valid = aw_out_v;
    mst_req_o.w        = w_mem_q[w_rd_q];
    mst_req_o.w_valid  = w_out_v;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = ~aw_full;
    slv_resp_o.w_ready  = ~w_full;
  end

  assign busy_o = ~aw_empty | ~w_empty | (iss_q != '0);

  // Full W FIFO with nothing complete and nothing draining means a burst exceeds WDepth
  a_burst_len: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_full && cmpl_q == '0 && !aw_empty && iss_q == '0))
    else $error("W burst longer than WDepth");
  a_cmpl_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cmpl_q <= WCntW'(WDepth))
    else $error("cmpl_q overflow");
  a_iss_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    iss_q <= AwCntW'(NumAw))
    else $error("iss_q overflow");

endmodule

// File: tb/tb_axi_wburst_buffer.sv
// Directed bench for axi_wburst_buffer: latency, ordering, backpressure,
// reset and pass-through, all against hand-computed expectations.
module tb_axi_wburst_buffer;
  import axi_wburst_pkg::*;

  logic  clk, rst_n;
  req_t  slv_req, mst_req;
  resp_t slv_resp, mst_resp;
  logic  busy;
  int    checks = 0;
  int    errors = 0;

  axi_wburst_buffer #(
    .NumAw (4),
    .WDepth(8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic aw_chan_t mk_aw(logic [3:0] id, logic [31:0] addr,
                                     logic [7:0] len);
    aw_chan_t a;
    a       = '0;
    a.id    = id;
    a.addr  = addr;
    a.len   = len;
    a.size  = 3'd3;
    a.burst = 2'd1;
    return a;
  endfunction

  function automatic w_chan_t mk_w(logic [63:0] d, logic l);
    w_chan_t w;
    w.data = d;
    w.strb = 8'hFF;
    w.last = l;
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0]  got_id[$];
    logic [63:0] got_d[$];
    int          wi;
    bit          aw4_done;
    bit          in_aw, in_w;

    slv_req  = '0;
    mst_resp = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    slv_req.ar_valid = 1'b1;
    slv_req.ar       = mk_aw(4'h8, 32'h1000, 8'd0);
    mst_resp.r_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_aw_valid", mst_req.aw_valid, 1'b0);
    chk("rst_w_valid", mst_req.w_valid, 1'b0);
    chk("rst_aw_ready", slv_resp.aw_ready, 1'b1);
    chk("rst_w_ready", slv_resp.w_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ar_pt", {mst_req.ar_valid, mst_req.ar.id}, {1'b1, 4'h8});
    chk("rst_r_pt", slv_resp.r_valid, 1'b1);

    slv_req  = '0;
    mst_resp = '0;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Test 1: AW first, W beats with idle gap
    slv_req.aw = mk_aw(4'hC, 32'h100, 8'd1);
    slv_req.aw_valid = 1'b1;
    settle();
    chk("t1_aw_ready", slv_resp.aw_ready, 1'b1);
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w = mk_w(64'hA0, 1'b0);
    slv_req.w_valid = 1'b1;
    settle();
    chk("t1_no_aw", mst_req.aw_valid, 1'b0);
    chk("t1_busy", busy, 1'b1);
    tick();
    slv_req.w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t1_idle_aw", mst_req.aw_valid, 1'b0);
      tick();
    end
    slv_req.w = mk_w(64'hA1, 1'b1);
    slv_req.w_valid = 1'b1;
    settle();
    chk("t1_last_cyc_aw", mst_req.aw_valid, 1'b0);
    tick();
    slv_req.w_valid = 1'b0;
    settle();
    chk("t1_aw_out", {mst_req.aw_valid, mst_req.aw.id, mst_req.aw.len},
        {1'b1, 4'hC, 8'd1});
    chk("t1_w_early", mst_req.w_valid, 1'b0);
    tick();
    settle();
    chk("t1_w0", {mst_req.w_valid, mst_req.w.last, mst_req.w.data},
        {1'b1, 1'b0, 64'hA0});
    tick();
    settle();
    chk("t1_w1", {mst_req.w_valid, mst_req.w.last, mst_req.w.data},
        {1'b1, 1'b1, 64'hA1});
    chk("t1_aw_gone", mst_req.aw_valid, 1'b0);
    tick();
    settle();
    chk("t1_end", {mst_req.w_valid, busy}, 2'b00);
    tick();

    // Test 2: whole W burst before its AW
    for (int i = 0; i < 4; i++) begin
      slv_req.w = mk_w(64'hB0 + 64'(i), i == 3);
      slv_req.w_valid = 1'b1;
      settle();
      chk("t2_hold_aw", mst_req.aw_valid, 1'b0);
      tick();
    end
    slv_req.w_valid = 1'b0;
    settle();
    chk("t2_wait", {mst_req.aw_valid, mst_req.w_valid}, 2'b00);
    tick();
    slv_req.aw = mk_aw(4'h3, 32'h200, 8'd3);
    slv_req.aw_valid = 1'b1;
    settle();
    chk("t2_push_cyc", mst_req.aw_valid, 1'b0);
    tick();
    slv_req.aw_valid = 1'b0;
    settle();
    chk("t2_aw_out", {mst_req.aw_valid, mst_req.aw.id, mst_req.aw.len},
        {1'b1, 4'h3, 8'd3});
    chk("t2_w_early", mst_req.w_valid, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t2_beat", {mst_req.w_valid, mst_req.w.last, mst_req.w.data},
          {1'b1, i == 3, 64'hB0 + 64'(i)});
      tick();
    end
    settle();
    chk("t2_idle", {mst_req.w_valid, busy}, 2'b00);
    tick();

    // Test 3: AW FIFO full while W withheld
    for (int k = 0; k < 4; k++) begin
      slv_req.aw = mk_aw(4'(k), 32'h300 + 32'(k * 16), 8'd0);
      slv_req.aw_valid = 1'b1;
      settle();
      chk("t3_aw_rdy", slv_resp.aw_ready, 1'b1);
      tick();
    end
    slv_req.aw = mk_aw(4'h4, 32'h340, 8'd0);
    settle();
    chk("t3_aw_full", slv_resp.aw_ready, 1'b0);
    chk("t3_w_rdy", slv_resp.w_ready, 1'b1);
    chk("t3_no_issue", mst_req.aw_valid, 1'b0);
    wi = 0;
    aw4_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      slv_req.aw_valid = !aw4_done;
      slv_req.w_valid  = wi < 5;
      slv_req.w        = mk_w(64'hD0 + 64'(wi), 1'b1);
      settle();
      in_aw = slv_req.aw_valid & slv_resp.aw_ready;
      in_w  = slv_req.w_valid & slv_resp.w_ready;
      if (mst_req.aw_valid & mst_resp.aw_ready)
        got_id.push_back(mst_req.aw.id);
      if (mst_req.w_valid & mst_resp.w_ready)
        got_d.push_back(mst_req.w.data);
      tick();
      if (in_aw) aw4_done = 1'b1;
      if (in_w) wi++;
    end
    chk("t3_n_aw", got_id.size(), 5);
    chk("t3_n_w", got_d.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t3_aw_order", (i < got_id.size()) ? got_id[i] : 4'hF, 4'(i));
      chk("t3_w_order", (i < got_d.size()) ? got_d[i] : '1,
          64'hD0 + 64'(i));
    end
    chk("t3_idle", {busy, slv_resp.aw_ready}, 2'b01);

    // Test 4: interconnect w_ready toggling
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    mst_resp.w_ready = 1'b0;
    slv_req.aw = mk_aw(4'h5, 32'h400, 8'd3);
    slv_req.aw_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slv_req.w = mk_w(64'hE0 + 64'(i), i == 3);
      slv_req.w_valid = 1'b1;
      tick();
      slv_req.aw_valid = 1'b0;
    end
    slv_req.w_valid = 1'b0;
    settle();
    chk("t4_aw_out", {mst_req.aw_valid, mst_req.aw.id}, {1'b1, 4'h5});
    tick();
    for (int k = 0; k < 8; k++) begin
      mst_resp.w_ready = (k % 2) == 1;
      settle();
      chk("t4_beat", {mst_req.w_valid, mst_req.w.last, mst_req.w.data},
          {1'b1, (k / 2) == 3, 64'hE0 + 64'(k / 2)});
      tick();
    end
    mst_resp.w_ready = 1'b1;
    settle();
    chk("t4_end", {mst_req.w_valid, busy}, 2'b00);
    tick();

    // Test 5: reset mid-burst
    slv_req.aw = mk_aw(4'h6, 32'h500, 8'd3);
    slv_req.aw_valid = 1'b1;
    slv_req.w = mk_w(64'hF0, 1'b0);
    slv_req.w_valid = 1'b1;
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w = mk_w(64'hF1, 1'b0);
    tick();
    slv_req.w_valid = 1'b0;
    settle();
    chk("t5_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    settle();
    chk("t5_rst_out", {mst_req.aw_valid, mst_req.w_valid, busy}, 3'b000);
    chk("t5_rst_rdy", {slv_resp.aw_ready, slv_resp.w_ready}, 2'b11);
    tick();
    rst_n = 1'b1;
    tick();
    slv_req.aw = mk_aw(4'h7, 32'h600, 8'd0);
    slv_req.aw_valid = 1'b1;
    slv_req.w = mk_w(64'h60, 1'b1);
    slv_req.w_valid = 1'b1;
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    settle();
    chk("t5_aw_out", {mst_req.aw_valid, mst_req.aw.id}, {1'b1, 4'h7});
    tick();
    settle();
    chk("t5_beat", {mst_req.w_valid, mst_req.w.last, mst_req.w.data},
        {1'b1, 1'b1, 64'h60});
    tick();
    settle();
    chk("t5_end", {mst_req.w_valid, mst_req.aw_valid, busy}, 3'b000);
    tick();

    // Test 6: AR/R/B pass-through alongside a buffered write
    for (int i = 0; i < 6; i++) begin
      slv_req.aw = mk_aw(4'h9, 32'h700, 8'd0);
      slv_req.aw_valid = i == 0;
      slv_req.w = mk_w(64'h90, 1'b1);
      slv_req.w_valid = i == 0;
      slv_req.ar = mk_aw(4'h8, 32'h2000 + 32'(i * 8), 8'(i));
      slv_req.ar_valid = (i % 2) == 1;
      slv_req.r_ready  = ((i / 2) % 2) == 1;
      slv_req.b_ready  = ((i / 2) % 2) == 0;
      mst_resp.ar_ready = (i % 3) == 0;
      mst_resp.r.id    = 4'h8;
      mst_resp.r.data  = 64'h5500 + 64'(i);
      mst_resp.r.last  = 1'b1;
      mst_resp.r_valid = (i % 2) == 0;
      mst_resp.b.id    = 4'h8;
      mst_resp.b.resp  = 2'(i);
      mst_resp.b_valid = i >= 3;
      settle();
      chk("t6_ar", {mst_req.ar_valid, mst_req.ar.id, mst_req.ar.addr,
                    mst_req.ar.len},
          {(i % 2) == 1, 4'h8, 32'h2000 + 32'(i * 8), 8'(i)});
      chk("t6_rdy", {mst_req.r_ready, mst_req.b_ready,
                     slv_resp.ar_ready},
          {((i / 2) % 2) == 1, ((i / 2) % 2) == 0, (i % 3) == 0});
      chk("t6_r", {slv_resp.r_valid, slv_resp.r.id, slv_resp.r.data},
          {(i % 2) == 0, 4'h8, 64'h5500 + 64'(i)});
      chk("t6_b", {slv_resp.b_valid, slv_resp.b.id, slv_resp.b.resp},
          {i >= 3, 4'h8, 2'(i)});
      tick();
    end
    settle();
    chk("t6_write_done", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
